// File: rtl/data_memory_unit.sv
// Byte-addressed little-endian 64-bit data memory: combinational loads, clocked stores.
// Optional macro DMEM_TRACE_EN adds a simulation-only per-edge access trace.
module data_memory_unit #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       write_data,
    output logic [63:0]       read_data
);
    localparam int IDX_W = $clog2(MEM_BYTES);

    logic [7:0]       r_mem [MEM_BYTES];
    logic             w_in_range;
    logic [IDX_W-1:0] w_base;

    // Compare against the last legal base so A+7 can never overflow ADDR_W.
    assign w_in_range = (address <= ADDR_W'(MEM_BYTES - 8));
    assign w_base     = address[IDX_W-1:0];

    always_comb begin
        read_data = 64'h0;
        if (rst_n && mem_read && w_in_range) begin
            for (int k = 0; k < 8; k++) begin
                read_data[8*k +: 8] = r_mem[w_base + IDX_W'(k)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[IDX_W'(i)] <= 8'h00;
            end
        end else if (mem_write && w_in_range) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[w_base + IDX_W'(k)] <= write_data[8*k +: 8];
            end
        end
    end

`ifdef DMEM_TRACE_EN
    always @(posedge clk) begin
        if (rst_n) begin
            if ((mem_read || mem_write) && !w_in_range)
                $display("dmem: out-of-range %h", address);
            else begin
                if (mem_write)
                    $display("dmem: store %h to %h", write_data, address);
                if (mem_read)
                    $display("dmem: load %h from %h", read_data, address);
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit with hand-computed expectations.
module tb_data_memory_unit;
    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] address;
    logic [63:0] write_data;
    logic [63:0] read_data;

    int n_checks;
    int n_fail;

    data_memory_unit #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_store(input logic [63:0] a, input logic [63:0] d);
        address    = a;
        write_data = d;
        mem_write  = 1'b1;
        mem_read   = 1'b0;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [63:0] a, input logic [63:0] exp);
        address  = a;
        mem_read = 1'b1;
        #1;
        chk_val(tag, read_data, exp);
        mem_read = 1'b0;
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 64'h0;
        write_data = 64'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_load("rst_a0",    64'd0,    64'h0);
        do_load("rst_a8",    64'd8,    64'h0);
        do_load("rst_a1016", 64'd1016, 64'h0);

        do_store(64'd16, 64'h0123456789ABCDEF);
        do_load("rt_a16", 64'd16, 64'h0123456789ABCDEF);
        address  = 64'd16;
        mem_read = 1'b0;
        #1;
        chk_val("noread_a16", read_data, 64'h0);

        do_load("mis_a17", 64'd17, 64'h000123456789ABCD);
        do_store(64'd20, 64'hFFFF_FFFF_FFFF_FFFF);
        do_load("ovl_a16", 64'd16, 64'hFFFFFFFF89ABCDEF);

        // Read-during-write: old data this cycle, new data next cycle.
        do_store(64'd40, 64'h11);
        address    = 64'd40;
        write_data = 64'h22;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        #1;
        chk_val("rdw_old", read_data, 64'h11);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        #1;
        chk_val("rdw_new", read_data, 64'h22);
        mem_read = 1'b0;

        do_store(64'd1016, 64'hAA);
        do_load("top_a1016", 64'd1016, 64'hAA);
        do_store(64'd1017, 64'h5555_6666_7777_8888);
        do_load("oor_a1017", 64'd1017, 64'h0);
        do_load("keep_a1016", 64'd1016, 64'hAA);
        do_load("wrap_a0", 64'd0, 64'h0);
        do_load("oor_big", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);

        address = 64'd1016;
        #1;
        chk_val("idle_zero", read_data, 64'h0);

        // Reset forces read_data low and suppresses a concurrent write.
        rst_n      = 1'b0;
        mem_read   = 1'b1;
        mem_write  = 1'b1;
        address    = 64'd1016;
        write_data = 64'h1234;
        #1;
        chk_val("rst_force", read_data, 64'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        do_load("mrst_a16",   64'd16,   64'h0);
        do_load("mrst_a1016", 64'd1016, 64'h0);
        do_load("mrst_a40",   64'd40,   64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
